keypad_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad, debounces presses and releases, and drives `keypad_pressed` / `key[4:0]` into the game state machine.
- Sits directly upstream of the game FSM.
- Key codes consumed downstream: 13 = PWRB, 10 = STB, 15 = YES, 14 = NO.
- Runs on the 27 MHz board clock.

---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with press and release debounce
module keypad_scanner #(
  parameter int SCAN_DIV        = 27000,
  parameter int DEBOUNCE_CYCLES = 540000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       keypad_pressed,
  output logic [4:0] key
);

  localparam logic [4:0]       KEY_NONE  = 5'd31;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state, state_n;
  logic [3:0]       sync1, rs;
  logic [CNT_W-1:0] settle_cnt, settle_n;
  logic [CNT_W-1:0] deb_cnt, deb_n;
  logic [1:0]       col_idx, col_idx_n;
  logic [1:0]       cand_row, cand_row_n;
  logic [1:0]       cand_col, cand_col_n;
  logic [1:0]       low_row;
  logic [4:0]       key_n;
  logic             pressed_n;
  logic             cand_low;

  assign col      = ~(4'b0001 << col_idx);
  assign cand_low = ~rs[cand_row];

  // two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'b1111;
      rs    <= 4'b1111;
    end else begin
      sync1 <= row;
      rs    <= sync1;
    end
  end

  // lowest-numbered low row wins when several rows are pulled down
  always_comb begin
    low_row = 2'd3;
    if (!rs[0])      low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
  end

  // scan / debounce / hold / release sequencing and output updates
  always_comb begin
    state_n    = state;
    settle_n   = settle_cnt;
    deb_n      = deb_cnt;
    col_idx_n  = col_idx;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    key_n      = key;
    pressed_n  = keypad_pressed;
    unique case (state)
      SCAN: begin
        if (settle_cnt == SCAN_LAST) begin
          settle_n = '0;
          if (rs == 4'b1111) begin
            col_idx_n = col_idx + 2'd1;
          end else begin
            cand_row_n = low_row;
            cand_col_n = col_idx;
            deb_n      = CNT_ONE;
            state_n    = DEBOUNCE;
          end
        end else begin
          settle_n = settle_cnt + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (!cand_low) begin
          deb_n    = '0;
          settle_n = '0;
          state_n  = SCAN;
        end else if (deb_cnt == DEB_LAST) begin
          deb_n     = '0;
          key_n     = {1'b0, cand_row, cand_col};
          pressed_n = 1'b1;
          state_n   = HELD;
        end else begin
          deb_n = deb_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!cand_low) begin
          deb_n   = CNT_ONE;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (cand_low) begin
          deb_n   = '0;
          state_n = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          deb_n     = '0;
          key_n     = KEY_NONE;
          pressed_n = 1'b0;
          col_idx_n = col_idx + 2'd1;
          settle_n  = '0;
          state_n   = SCAN;
        end else begin
          deb_n = deb_cnt + CNT_ONE;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  // state, counters, candidate and outputs register
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SCAN;
      settle_cnt     <= '0;
      deb_cnt        <= '0;
      col_idx        <= 2'd0;
      cand_row       <= 2'd0;
      cand_col       <= 2'd0;
      key            <= KEY_NONE;
      keypad_pressed <= 1'b0;
    end else begin
      state          <= state_n;
      settle_cnt     <= settle_n;
      deb_cnt        <= deb_n;
      col_idx        <= col_idx_n;
      cand_row       <= cand_row_n;
      cand_col       <= cand_col_n;
      key            <= key_n;
      keypad_pressed <= pressed_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with keypad matrix model
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        keypad_pressed;
  logic [4:0]  key;
  logic [15:0] keys = '0;

  int cyc = 0;
  bit started = 0;
  bit model_on = 0;
  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .keypad_pressed(keypad_pressed), .key(key)
  );

  always #5 clk = ~clk;

  // physical matrix: a pressed key pulls its row low only while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
  end

  // edge counter relative to the latest bench-controlled reset release
  always @(posedge clk) cyc <= started ? cyc + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // behavioural model: column scan, run-length debounce of the candidate row
  int m_col, m_tmr, m_cand, m_ccol, m_run, m_key;
  bit m_pressed;
  logic [3:0] p1, p2, m_s;
  always @(posedge clk) begin
    if (rst) begin
      m_col = 0; m_tmr = 0; m_cand = -1; m_ccol = 0; m_run = 0;
      m_pressed = 0; m_key = 31; p1 = 4'hF; p2 = 4'hF; model_on = 1;
    end else begin
      m_s = p2;
      if (!m_pressed && m_cand < 0) begin
        if (m_tmr == SD - 1) begin
          m_tmr = 0;
          if (m_s == 4'hF) m_col = (m_col + 1) % 4;
          else begin
            m_cand = 3;
            for (int r = 3; r >= 0; r--) if (!m_s[r]) m_cand = r;
            m_ccol = m_col;
            m_run = 1;
          end
        end else m_tmr++;
      end else if (!m_pressed) begin
        if (m_s[m_cand]) begin m_cand = -1; m_run = 0; end
        else begin
          m_run++;
          if (m_run == DB) begin m_pressed = 1; m_key = 4 * m_cand + m_ccol; m_run = 0; end
        end
      end else begin
        if (m_s[m_cand]) begin
          m_run++;
          if (m_run == DB) begin
            m_pressed = 0; m_key = 31; m_cand = -1;
            m_col = (m_col + 1) % 4; m_tmr = 0; m_run = 0;
          end
        end else m_run = 0;
      end
      p2 = p1;
      p1 = row;
    end
  end

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (model_on) begin
      check("col", col, 15 - (1 << m_col));
      check("pressed", keypad_pressed, m_pressed);
      check("key", key, m_key);
      check("key_vs_pressed", key != 5'd31, keypad_pressed);
    end
  end

  // record output transitions for the directed timing checks
  int rises = 0, falls = 0, rise_cyc = -1, fall_cyc = -1, rise_key = -1;
  logic prev_p = 1'b0;
  always @(negedge clk) begin
    if (keypad_pressed === 1'b1 && prev_p === 1'b0) begin rises++; rise_cyc = cyc; rise_key = key; end
    if (keypad_pressed === 1'b0 && prev_p === 1'b1) begin falls++; fall_cyc = cyc; end
    prev_p = keypad_pressed;
  end

  logic [3:0] idle_tab [17] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                                4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE};
  int r0;

  // directed stimulus timeline
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; started = 1;
    check("rst_col", col, 4'b1110);
    check("rst_pressed", keypad_pressed, 0);
    check("rst_key", key, 31);
    for (int k = 1; k <= 16; k++) begin
      at(k);
      check("idle_col", col, idle_tab[k]);
    end

    rst = 1'b1; started = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0; started = 1;
    keys[13] = 1'b1;
    at(14); check("clean_not_yet", keypad_pressed, 0);
    at(16); check("clean_rise_cyc", rise_cyc, 15); check("clean_rise_key", rise_key, 13);
    at(20); keys[13] = 1'b0;
    at(30); keys[10] = 1'b1; r0 = rises;
    at(32); check("clean_fall_cyc", fall_cyc, 30); check("clean_next_col", col, 4'b1011);
    at(35); keys[10] = 1'b0;
    at(36); keys[10] = 1'b1;
    at(50); check("bounce_rise_cyc", rise_cyc, 49); check("bounce_key", rise_key, 10);
    check("bounce_single", rises - r0, 1);
    at(56); keys[10] = 1'b0;
    at(66); keys[15] = 1'b1;
    at(67); check("bounce_fall_cyc", fall_cyc, 66);
    at(78); check("rel_rise_cyc", rise_cyc, 77); check("rel_key", rise_key, 15); r0 = rises;
    at(85); keys[15] = 1'b0;
    at(90); keys[15] = 1'b1;
    at(92); keys[15] = 1'b0;
    at(100); check("rel_glitch_held", keypad_pressed, 1);
    at(102); keys[6] = 1'b1; keys[14] = 1'b1;
    at(104); check("rel_fall_cyc", fall_cyc, 102); check("rel_no_reassert", rises - r0, 0);
    at(122); check("prio_rise_cyc", rise_cyc, 121); check("prio_key", rise_key, 6);
    at(125); keys[6] = 1'b0;
    at(136); check("prio_fall_cyc", fall_cyc, 135);
    at(159); check("redetect_rise_cyc", rise_cyc, 158); check("redetect_key", rise_key, 14);
    at(160); keys[14] = 1'b0;
    at(170); keys[13] = 1'b1;
    at(171); check("redetect_fall_cyc", fall_cyc, 170);
    at(190); check("held_rise_cyc", rise_cyc, 189); check("held_key", rise_key, 13);
    at(192); rst = 1'b1;
    at(193); rst = 1'b0;
    at(194); check("midrst_fall_cyc", fall_cyc, 193); check("midrst_col", col, 4'b1110);
    at(209); check("midrst_rise_cyc", rise_cyc, 208); check("midrst_key", rise_key, 13);
    at(210); keys = '0;
    at(225);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
